// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. The winning word is tagged with its source ID and
// registered onto wr_en/din; stalls caused by a full FIFO are counted.
`timescale 1ns/1ps
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           full,
    output logic                           wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] din,
    output logic [ID_WIDTH-1:0]            last_grant,
    output logic [15:0]                    drop_stall
);

    localparam logic [ID_WIDTH-1:0] RESET_GRANT = ID_WIDTH'(NUM_REQ - 1);

    // Saturating increment: the stall counter sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

    logic                           wr_en_q, wr_en_d;
    logic [ID_WIDTH+DATA_WIDTH-1:0] din_q, din_d;
    logic [ID_WIDTH-1:0]            last_grant_q, last_grant_d;
    logic [15:0]                    drop_stall_q, drop_stall_d;

    logic                           grant_ok;
    logic                           found;
    logic [ID_WIDTH-1:0]            win_id;
    logic [DATA_WIDTH-1:0]          win_data;
    logic [NUM_REQ-1:0]             win_onehot;

    // Round-robin search starting one past the previous winner; full or
    // reset suppresses every grant, which also freezes the pointer.
    always_comb begin
        found      = 1'b0;
        win_id     = '0;
        win_data   = '0;
        win_onehot = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] &&
                    ((int'(last_grant_q) + k) % NUM_REQ) == i) begin
                    found         = 1'b1;
                    win_id        = ID_WIDTH'(i);
                    win_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                    win_onehot[i] = 1'b1;
                end
            end
        end
        grant_ok  = !rst && !full && found;
        req_ready = grant_ok ? win_onehot : '0;
    end

    // Next-state for the registered write stage and the stall counter.
    always_comb begin
        wr_en_d      = grant_ok;
        din_d        = grant_ok ? {win_id, win_data} : '0;
        last_grant_d = grant_ok ? win_id : last_grant_q;
        drop_stall_d = (full && (|req_valid)) ? sat_inc16(drop_stall_q) : drop_stall_q;
    end

    // Output registers; reset discards any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            din_q        <= '0;
            last_grant_q <= RESET_GRANT;
            drop_stall_q <= 16'd0;
        end else begin
            wr_en_q      <= wr_en_d;
            din_q        <= din_d;
            last_grant_q <= last_grant_d;
            drop_stall_q <= drop_stall_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign din        = din_q;
    assign last_grant = last_grant_q;
    assign drop_stall = drop_stall_q;

    // At most one requester may be accepted per cycle.
    always @(posedge clk) begin
        assert ($onehot0(req_ready));
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of an input-event FIFO among NUM_REQ producers, such as the button, switch and rotary-encoder front-ends.
- Arbitrates round-robin among requesters asserting valid, accepting at most one word per cycle.
- Registers the winning word, tagged with its source ID, onto wr_en/din toward the FIFO.
- Sits between the I/O front-ends and the FIFO read by the CPU's MMIO path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, payload width per requester
ID_WIDTH, 2, source-ID tag width; must satisfy 2**ID_WIDTH >= NUM_REQ

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  requester i has a word pending
req_data  input  NUM_REQ*DATA_WIDTH  payload of requester i, bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  word of requester i accepted this cycle (combinational)
full  input  1  FIFO full flag; must assert when <=1 free entry remains
wr_en  output  1  registered FIFO write strobe
din  output  ID_WIDTH+DATA_WIDTH  registered FIFO write data {src_id, payload}
last_grant  output  ID_WIDTH  registered ID of most recent winner
drop_stall  output  16  registered count of cycles with any valid while full=1, saturating

Behaviour:
- Reset (rst=1 at clk edge): wr_en=0, din=0, last_grant=NUM_REQ-1 so requester 0 has top priority after reset, drop_stall=0. req_ready is 0 throughout any cycle in which rst=1.
- Arbitration (combinational, each cycle):
  - Search order is last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - The winner is the first index with req_valid=1.
  - grant_ok = !rst && !full && |req_valid.
  - req_ready is one-hot at the winner when grant_ok, otherwise all zero.
  - At most one req_ready bit is set per cycle.
- Handshake:
  - A transfer occurs on requester i when req_valid[i] && req_ready[i].
  - Requesters hold req_valid and req_data stable until accepted.
  - The arbiter never depends on a requester deasserting valid.
- Output stage:
  - On a cycle with a transfer, the next edge loads wr_en=1, din={winner ID zero-extended to ID_WIDTH, req_data[winner]}, last_grant=winner.
  - With no transfer, the next edge loads wr_en=0 and din=0; last_grant holds.
  - Write latency is 1 cycle from acceptance.
  - Throughput is 1 word per cycle while !full.
- Full:
  - When full=1, no acceptance occurs and the round-robin pointer is frozen.
  - Because of the registered write, full is required to lead true-full by one entry; the integrator sets the FIFO's programmable full accordingly.
- drop_stall: increments by 1 on each cycle with full=1 && |req_valid && !rst; saturates at 16'hFFFF and does not wrap.
- Fairness:
  - With all NUM_REQ requesters continuously valid and full=0, grants cycle 0,1,2,...,NUM_REQ-1,0,...
  - Any valid requester is granted within NUM_REQ accepting cycles.
- Wrap-around: the search index wraps modulo NUM_REQ. The values NUM_REQ..2**ID_WIDTH-1 never appear as winners.
- Reset mid-operation: a pending registered write is discarded (wr_en=0 on the reset edge). Nothing accepted during the reset cycle is written.
- Simultaneous full rise and valid: full is sampled in the same cycle as valid, so no grant that cycle.
- Single requester: back-to-back grants to the same index are allowed when it is the only one valid.

Test Plan:
- Reset, then req_valid=4'b1111 with data 0x10,0x11,0x12,0x13 held and full=0 -> wr_en=1 for 4 consecutive cycles starting one cycle after the first acceptance, with din=0x010,0x111,0x212,0x313, then repeating in that order.
- Single requester 2 valid, data 0xA5, full=0 for 3 cycles -> req_ready=4'b0100 each cycle, din=0x2A5 three times, last_grant=2.
- req_valid=4'b1111, full=1 for 5 cycles -> req_ready=0, wr_en=0, drop_stall=5. On full=0, the next grant is last_grant+1.
- Last grant=3, then req_valid=4'b1001 -> winner is 0 (wrap), then 3, then 0, alternating.
- rst asserted the cycle after an acceptance -> wr_en=0 and din=0 at that edge, last_grant=3, drop_stall=0. After release, requester 0 has priority.
- full=1 with req_valid=1 held for 70000 cycles -> drop_stall saturates at 0xFFFF and stays.
